// File: rtl/pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_bank
//  Description : Multi-channel PWM generator with prescaler, enable mask and
//                period-aligned (double-buffered) duty updates. Define
//                PWM_BANK_RAMP_EN to slew active duties by one count per period.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_bank #(
    parameter int         CH_NUM    = 10,
    parameter int         CNT_W     = 8,
    parameter logic [7:0] BASE_ADR  = 8'h01,
    parameter logic [7:0] PRESC_ADR = 8'hF0,
    parameter logic [7:0] MASK_ADR  = 8'hF1
) (
    input  logic              clk25M,
    input  logic              reset_n,
    input  logic [15:0]       byte_data_received,
    input  logic              byte_received,
    output logic [CH_NUM-1:0] pwm_out,
    output logic              period_start
);

    logic [7:0]       w_adr;
    logic [7:0]       w_pay;
    logic             w_tick;
    logic             w_period_end;
    logic [7:0]       r_presc_reg;
    logic [7:0]       r_presc_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_period_start;

    assign w_adr        = byte_data_received[15:8];
    assign w_pay        = byte_data_received[7:0];
    assign w_tick       = (r_presc_cnt == r_presc_reg);
    assign w_period_end = w_tick && (&r_cnt);
    assign period_start = r_period_start;

    always_ff @(posedge clk25M) begin
        if (!reset_n) begin
            r_presc_reg    <= 8'd0;
            r_presc_cnt    <= 8'd0;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (byte_received && (w_adr == PRESC_ADR)) begin
                r_presc_reg <= w_pay;
            end
            // Equality compare: lowering the prescale below the running count
            // lets the counter wrap through 255 before the next tick.
            r_presc_cnt    <= w_tick ? 8'd0 : r_presc_cnt + 8'd1;
            if (w_tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_period_start <= w_period_end;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        localparam logic [7:0] c_ch_adr   = 8'(BASE_ADR + i);
        localparam logic [7:0] c_mask_adr = (i < 8) ? MASK_ADR : 8'(MASK_ADR + 8'd1);
        localparam int         c_mask_bit = i % 8;

        logic [7:0]       r_pend;
        logic [7:0]       r_act;
        logic             r_mask;
        logic             r_pwm;
        logic [CNT_W-1:0] w_act_ext;

        assign w_act_ext  = CNT_W'(r_act) << (CNT_W - 8);
        assign pwm_out[i] = r_pwm;

        always_ff @(posedge clk25M) begin
            if (!reset_n) begin
                r_pend <= 8'd0;
                r_act  <= 8'd0;
                r_mask <= 1'b1;
                r_pwm  <= 1'b0;
            end else begin
                if (byte_received && (w_adr == c_ch_adr)) begin
                    r_pend <= w_pay;
                end
                // Active duty samples the pending value held before this edge,
                // so a same-cycle write lands one period later.
                if (w_period_end) begin
`ifdef PWM_BANK_RAMP_EN
                    if (r_act < r_pend) begin
                        r_act <= r_act + 8'd1;
                    end else if (r_act > r_pend) begin
                        r_act <= r_act - 8'd1;
                    end
`else
                    r_act <= r_pend;
`endif
                end
                if (byte_received && (w_adr == c_mask_adr)) begin
                    r_mask <= w_pay[c_mask_bit];
                end
                r_pwm <= r_mask && (w_act_ext > r_cnt);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_bank
//  Description : Self-checking bench for pwm_bank against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_bank;

    localparam int CH    = 10;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int SCALE = 1 << (CW - 8);

    logic          clk25M = 1'b0;
    logic          reset_n;
    logic [15:0]   byte_data_received;
    logic          byte_received;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #20 clk25M = ~clk25M;

    pwm_bank #(
        .CH_NUM    (CH),
        .CNT_W     (CW),
        .BASE_ADR  (8'h01),
        .PRESC_ADR (8'hF0),
        .MASK_ADR  (8'hF1)
    ) dut (
        .clk25M             (clk25M),
        .reset_n            (reset_n),
        .byte_data_received (byte_data_received),
        .byte_received      (byte_received),
        .pwm_out            (pwm_out),
        .period_start       (period_start)
    );

    // Behavioural model: state advanced once per rising edge from the rules.
    int        m_pend [CH];
    int        m_act  [CH];
    bit        m_mask [CH];
    int        m_pr, m_pc, m_cnt;
    bit [CH-1:0] m_pwm;
    bit        m_ps;

    always @(posedge clk25M) begin
        bit tick, pend_end;
        int adr;
        logic [7:0] pay;
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                m_pend[i] = 0; m_act[i] = 0; m_mask[i] = 1'b1;
            end
            m_pr = 0; m_pc = 0; m_cnt = 0; m_pwm = '0; m_ps = 1'b0;
        end else begin
            tick     = (m_pc == m_pr);
            pend_end = tick && (m_cnt == CMAX);
            for (int i = 0; i < CH; i++)
                m_pwm[i] = m_mask[i] && (m_act[i] * SCALE > m_cnt);
            m_ps = pend_end;
            if (pend_end) begin
                for (int i = 0; i < CH; i++) begin
`ifdef PWM_BANK_RAMP_EN
                    if (m_act[i] < m_pend[i]) m_act[i] = m_act[i] + 1;
                    else if (m_act[i] > m_pend[i]) m_act[i] = m_act[i] - 1;
`else
                    m_act[i] = m_pend[i];
`endif
                end
            end
            if (byte_received) begin
                adr = int'(byte_data_received[15:8]);
                pay = byte_data_received[7:0];
                if (adr >= 8'h01 && adr < 8'h01 + CH) m_pend[adr - 8'h01] = int'(pay);
                else if (adr == 8'hF0) m_pr = int'(pay);
                else if (adr == 8'hF1) begin
                    for (int i = 0; i < CH && i < 8; i++) m_mask[i] = pay[i];
                end else if (adr == 8'hF2) begin
                    for (int i = 8; i < CH; i++) m_mask[i] = pay[i-8];
                end
            end
            m_pc  = tick ? 0 : (m_pc + 1) % 256;
            m_cnt = (m_cnt + (tick ? 1 : 0)) % (CMAX + 1);
        end
    end

    always @(negedge clk25M) begin
        if (chk_en) begin
            checks++;
            if (pwm_out !== m_pwm) begin
                errors++;
                $display("FAIL model_pwm t=%0t actual=%b required=%b", $time, pwm_out, m_pwm);
            end
            checks++;
            if (period_start !== m_ps) begin
                errors++;
                $display("FAIL model_period_start t=%0t actual=%b required=%b", $time, period_start, m_ps);
            end
        end
    end

    task automatic check_lit(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic cmd(input logic [7:0] adr, input logic [7:0] pay);
        @(negedge clk25M);
        byte_received      = 1'b1;
        byte_data_received = {adr, pay};
        @(negedge clk25M);
        byte_received      = 1'b0;
    endtask

    task automatic wait_ps(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk25M);
            n++;
        end while (period_start !== 1'b1 && n < maxc);
        if (period_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL period_start_timeout actual=none required=pulse within %0d", maxc);
        end
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk25M);
            if (pwm_out[ch] === 1'b1) hi++;
        end
    endtask

    initial begin
        int n, hi, anyhi, sel;
        logic [7:0] adr, pay;
        reset_n = 1'b0; byte_received = 1'b0; byte_data_received = 16'h0000;
        repeat (3) @(negedge clk25M);
        check_lit("reset_pwm", int'(pwm_out), 0);
        check_lit("reset_period_start", int'(period_start), 0);
        chk_en  = 1'b1;
        reset_n = 1'b1;

        wait_ps(600, n);
        wait_ps(600, n);
        check_lit("period_len_presc0", n, 256);

        cmd(8'h01, 8'h40);
        wait_ps(600, n); wait_ps(600, n);
`ifndef PWM_BANK_RAMP_EN
        count_high(0, 256, hi);
        check_lit("ch0_duty40_high", hi, 64);
`endif
        cmd(8'h03, 8'h00);
        wait_ps(600, n); wait_ps(600, n);
        count_high(2, 256, hi);
        check_lit("ch2_duty00_high", hi, 0);
        cmd(8'h03, 8'hFF);
        wait_ps(600, n); wait_ps(600, n);
`ifndef PWM_BANK_RAMP_EN
        count_high(2, 256, hi);
        check_lit("ch2_dutyFF_high", hi, 255);
`endif

        cmd(8'h01, 8'h80);
        cmd(8'hF0, 8'h03);
        wait_ps(3000, n); wait_ps(3000, n);
        wait_ps(3000, n);
        check_lit("period_len_presc3", n, 1024);
`ifndef PWM_BANK_RAMP_EN
        count_high(0, 1024, hi);
        check_lit("ch0_duty80_presc3_high", hi, 512);
`endif

        cmd(8'hF1, 8'hFE);
        @(negedge clk25M);
        check_lit("mask_ch0_low", int'(pwm_out[0]), 0);
        cmd(8'h20, 8'h77);
        cmd(8'hF1, 8'hFF);
        cmd(8'hF0, 8'h00);

        // Random traffic, including back-to-back strobes and unmapped addresses.
        repeat (4000) begin
            @(negedge clk25M);
            byte_received = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 9);
            pay = 8'($urandom_range(0, 255));
            if (sel <= 5)      adr = 8'(8'h01 + $urandom_range(0, 11));
            else if (sel == 6) begin adr = 8'hF0; pay = 8'($urandom_range(0, 2)); end
            else if (sel == 7) adr = 8'hF1;
            else if (sel == 8) adr = 8'hF2;
            else begin
                adr = 8'($urandom_range(0, 255));
                if (adr == 8'hF0) pay = 8'($urandom_range(0, 2));
            end
            byte_data_received = {adr, pay};
        end
        @(negedge clk25M);
        byte_received = 1'b0;

        cmd(8'hF0, 8'h00);
        cmd(8'hF1, 8'hFF);
        cmd(8'hF2, 8'hFF);
        cmd(8'h01, 8'h80);
        wait_ps(70000, n);
        repeat (100) @(negedge clk25M);
        reset_n = 1'b0;
        @(negedge clk25M);
        check_lit("midreset_pwm", int'(pwm_out), 0);
        check_lit("midreset_period_start", int'(period_start), 0);
        reset_n = 1'b1;
        anyhi = 0;
        repeat (300) begin
            @(negedge clk25M);
            if (pwm_out !== '0) anyhi++;
        end
        check_lit("after_reset_duties_cleared", anyhi, 0);

        cmd(8'h01, 8'h05);
        repeat (6) wait_ps(600, n);
        count_high(0, 256, hi);
        check_lit("ch0_duty05_high", hi, 5);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Parametrised multi-channel PWM generator driven by the 16-bit command word and strobe from the serial receiver.
- Command format: address in [15:8], payload in [7:0].
- Successor to the fixed 3-channel PWM block. Adds:
  - a configurable channel count and counter width
  - a clock prescaler
  - per-channel enable mask
  - double-buffered duty registers, so duty changes take effect glitch-free at period boundaries
- Feeds heater/fan drive outputs, including the exhaust ventilation channel.

Parameters:
- CH_NUM, 10, number of PWM channels (1..16).
- CNT_W, 8, period counter width (8..16); period is 2^CNT_W ticks.
- BASE_ADR, 8'h01, command address of channel 0; channel i uses BASE_ADR+i.
- PRESC_ADR, 8'hF0, command address of the prescaler register.
- MASK_ADR, 8'hF1, command address of enable mask, channels 0..7; MASK_ADR+1 holds channels 8..15.

Ports:
- clk25M, input, 1, system clock, 25 MHz.
- reset_n, input, 1, synchronous active-low reset.
- byte_data_received, input, 16, command word: [15:8] address, [7:0] payload.
- byte_received, input, 1, one-cycle strobe qualifying byte_data_received.
- pwm_out, output, CH_NUM, registered PWM outputs, one bit per channel.
- period_start, output, 1, one-cycle pulse on the first tick of each PWM period.

Behaviour:
- **Reset.** Reset is synchronous and active-low, sampled on the clk25M rising edge.
  - Cleared to 0: all pending duties, active duties, prescaler register, prescaler counter and period counter.
  - Set to all 1s: enable mask.
  - pwm_out = 0 and period_start = 0 on the cycle after reset is sampled low.
  - Reset asserted mid-period aborts the period; no partial state is retained.
- **Command decode.** Acts only in cycles where byte_received = 1. Let adr = byte_data_received[15:8].
  - adr in BASE_ADR..BASE_ADR+CH_NUM-1: pending_duty[adr-BASE_ADR] <= payload.
  - adr = PRESC_ADR: presc_reg <= payload.
  - adr = MASK_ADR: mask[7:0] <= payload.
  - adr = MASK_ADR+1 and CH_NUM > 8: mask[CH_NUM-1:8] <= payload, low bits used.
  - Any other address: ignored, no state change.
  - Back-to-back strobes on consecutive cycles are each honoured.
- **Prescaler.**
  - presc_cnt increments every clock.
  - When presc_cnt == presc_reg, tick = 1 and presc_cnt <= 0.
  - presc_reg = 0 gives a tick every clock.
  - A new presc_reg value takes effect on the next compare; if presc_cnt already exceeds the new value, it wraps through 255 first.
- **Period counter.**
  - cnt (CNT_W bits) increments on each tick and wraps from 2^CNT_W-1 to 0.
  - period_end = tick && cnt == all 1s.
  - period_start is registered and asserted the cycle after period_end.
- **Duty scaling.** An 8-bit duty is MSB-aligned to CNT_W: duty_ext = {duty, (CNT_W-8) zeros}.
- **Shadow update.**
  - On period_end, active_duty[i] <= pending_duty[i] for all channels simultaneously.
  - If a write and period_end occur in the same cycle, the active value loads the old pending value; the new value applies one period later.
- **Output.**
  - pwm_out[i] <= mask[i] && (active_ext[i] > cnt). Latency is one clock from cnt.
  - duty 0: output constantly low.
  - duty 255 at CNT_W = 8: high 255 of 256 ticks.
- **Mask changes** take effect immediately, with no period alignment; output is low from the second clock after the strobe.

Optional Feature:
- Macro PWM_BANK_RAMP_EN.
- **Defined:** on each period_end, active_duty moves toward pending_duty by exactly 1 count (+1 or -1), or holds if equal. This is a soft-start/slew limit: 0 to 255 takes 255 periods.
- **Undefined:** active_duty loads pending_duty directly at period_end, as described above. No ramp logic is synthesised.

Test Plan:
1. Reset then idle, CNT_W=8, presc=0: pwm_out all 0, period_start pulses every 256 clocks, cnt wraps 255 to 0.
2. Write 16'h0140 (ch0 duty 0x40) mid-period: ch0 stays low until the next period boundary, then is high for exactly 64 of 256 clocks per period.
3. Write 16'h0300 then 16'h03FF: ch2 constantly low, then high 255 of 256 clocks; duty 0 produces no glitch pulse.
4. Write 16'hF003 (prescaler 3): period = 1024 clocks, and ch0 duty 0x80 gives 512 high clocks.
5. Write 16'hF1FE with ch0 duty 0x80 active: pwm_out[0] low within 2 clocks, other channels unaffected. Write 16'h2077 (unmapped): no state change.
6. Assert reset_n = 0 for one clock mid-period with duties set: all outputs 0 next cycle and duties cleared. With PWM_BANK_RAMP_EN defined, write 16'h0105: active ch0 duty reaches 5 after 5 period_end events.
